// File: rtl/wb_rom_arbiter.sv
// Two-master Wishbone arbiter sharing the program ROM between instruction fetch (m0) and a second reader (m1).
// Define WB_ROM_ARBITER_ROUND_ROBIN_EN for round-robin contention; otherwise m0 has fixed priority.
module wb_rom_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADR_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // master 0: instruction fetch
    input  logic             m0_cyc,
    input  logic             m0_stb,
    input  logic [ADR_W-1:0] m0_adr,
    output logic [15:0]      m0_dat_o,
    output logic             m0_ack,
    output logic             m0_stall,
    // master 1: secondary reader
    input  logic             m1_cyc,
    input  logic             m1_stb,
    input  logic [ADR_W-1:0] m1_adr,
    output logic [15:0]      m1_dat_o,
    output logic             m1_ack,
    output logic             m1_stall,
    // ROM slave
    output logic             s_cyc,
    output logic             s_stb,
    output logic [ADR_W-1:0] s_adr,
    input  logic [15:0]      s_dat_s,
    input  logic             s_ack,
    input  logic             s_stall
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    state_t     state_reg, state_next;
    logic [3:0] count_reg, count_next;
    logic       full;
    logic       accept;
    logic       ack_valid;
    logic       pick1;

    assign full      = (count_reg == MAX_CNT);
    assign accept    = s_cyc & s_stb & ~s_stall;
    // An ack with nothing outstanding is a slave protocol error and is swallowed.
    assign ack_valid = s_ack & (count_reg != 4'd0);

`ifdef WB_ROM_ARBITER_ROUND_ROBIN_EN
    logic rr_ptr_reg;

    assign pick1 = m1_cyc & (~m0_cyc | rr_ptr_reg);

    // Point at the other master whenever a grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 1'b0;
        end else if ((state_reg == IDLE) && (m0_cyc || m1_cyc)) begin
            rr_ptr_reg <= ~pick1;
        end
    end
`else
    assign pick1 = m1_cyc & ~m0_cyc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({accept, ack_valid})
            2'b10:   count_next = count_reg + 4'd1;
            2'b01:   count_next = count_reg - 4'd1;
            default: count_next = count_reg;
        endcase
    end

    // A grant is held until its master has dropped cyc and every late ack has drained.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc || m1_cyc) begin
                    state_next = pick1 ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                if (!m0_cyc && (count_reg == 4'd0)) begin
                    state_next = IDLE;
                end
            end
            GRANT1: begin
                if (!m1_cyc && (count_reg == 4'd0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Acks arriving after an abort (cyc already low) are consumed, not routed.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_adr    = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        m0_stall = m0_stb;
        m1_stall = m1_stb;
        case (state_reg)
            GRANT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb & ~full;
                s_adr    = m0_adr;
                m0_ack   = ack_valid & m0_cyc;
                m0_stall = s_stall | full;
            end
            GRANT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb & ~full;
                s_adr    = m1_adr;
                m1_ack   = ack_valid & m1_cyc;
                m1_stall = s_stall | full;
            end
            default: begin
                s_cyc = 1'b0;
            end
        endcase
    end

    assign m0_dat_o = s_dat_s;
    assign m1_dat_o = s_dat_s;

endmodule

// File: tb/tb_wb_rom_arbiter.sv
// Scoreboard bench for wb_rom_arbiter: one DUT with MAX_OUTSTANDING=2 and one with MAX_OUTSTANDING=1.
module tb_wb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rom_clr;
    logic        rom_stall;
    int          rom_lat;
    int          cycle = 0;

    // drivers: index 0/1 = dut masters 0/1, index 2 = dut_b master 0
    logic        cyc_d [3];
    logic        stb_d [3];
    logic [15:0] adr_d [3];

    logic [15:0] m0_dat, m1_dat;
    logic        m0_ack, m1_ack, m0_stall, m1_stall;
    logic        s_cyc, s_stb, s_ack;
    logic [15:0] s_adr, s_dat;

    logic [15:0] b_m0_dat, b_m1_dat;
    logic        b_m0_ack, b_m1_ack, b_m0_stall, b_m1_stall;
    logic        b_s_cyc, b_s_stb, b_s_ack;
    logic [15:0] b_s_adr, b_s_dat;

    logic        pa_ack [4];
    logic [15:0] pa_dat [4];

    logic [15:0] q0[$], q1[$], q2[$];
    int          ack_cnt [3];
    int          first_ack [3];
    int          last_ack [3];
    int          start_cyc [3];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    wb_rom_arbiter #(.MAX_OUTSTANDING(2), .ADR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(cyc_d[0]), .m0_stb(stb_d[0]), .m0_adr(adr_d[0]),
        .m0_dat_o(m0_dat), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_cyc(cyc_d[1]), .m1_stb(stb_d[1]), .m1_adr(adr_d[1]),
        .m1_dat_o(m1_dat), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_adr(s_adr),
        .s_dat_s(s_dat), .s_ack(s_ack), .s_stall(rom_stall)
    );

    wb_rom_arbiter #(.MAX_OUTSTANDING(1), .ADR_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(cyc_d[2]), .m0_stb(stb_d[2]), .m0_adr(adr_d[2]),
        .m0_dat_o(b_m0_dat), .m0_ack(b_m0_ack), .m0_stall(b_m0_stall),
        .m1_cyc(1'b0), .m1_stb(1'b0), .m1_adr(16'h0000),
        .m1_dat_o(b_m1_dat), .m1_ack(b_m1_ack), .m1_stall(b_m1_stall),
        .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_adr(b_s_adr),
        .s_dat_s(b_s_dat), .s_ack(b_s_ack), .s_stall(rom_stall)
    );

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'd40503;
        return p ^ 16'h5A5A;
    endfunction

    // ROM with adjustable ack latency (1..4); acks even after cyc drops
    always @(posedge clk) begin
        if (rom_clr) begin
            for (int k = 0; k < 4; k++) begin
                pa_ack[k] <= 1'b0;
                pa_dat[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                pa_ack[k] <= pa_ack[k+1];
                pa_dat[k] <= pa_dat[k+1];
            end
            pa_ack[3] <= 1'b0;
            pa_dat[3] <= 16'h0000;
            if (s_cyc && s_stb && !rom_stall) begin
                pa_ack[rom_lat-1] <= 1'b1;
                pa_dat[rom_lat-1] <= rom_word(s_adr);
            end
        end
    end
    assign s_ack = pa_ack[0];
    assign s_dat = pa_dat[0];

    always @(posedge clk) begin
        if (rom_clr) begin
            b_s_ack <= 1'b0;
            b_s_dat <= 16'h0000;
        end else begin
            b_s_ack <= b_s_cyc & b_s_stb & ~rom_stall;
            b_s_dat <= rom_word(b_s_adr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic int qsize(input int m);
        case (m)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int m, input logic [15:0] v);
        case (m)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic logic [15:0] pop(input int m);
        case (m)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic logic stall_of(input int m);
        case (m)
            0:       return m0_stall;
            1:       return m1_stall;
            default: return b_m0_stall;
        endcase
    endfunction

    task automatic got_ack(input int m, input logic [15:0] d);
        logic [15:0] e;
        if (ack_cnt[m] == 0) first_ack[m] = cycle;
        last_ack[m] = cycle;
        ack_cnt[m]++;
        if (qsize(m) == 0) begin
            check($sformatf("m%0d_unexpected_ack", m), 32'd1, 32'd0);
        end else begin
            e = pop(m);
            check($sformatf("m%0d_data", m), {16'h0, d}, {16'h0, e});
            $display("ack m%0d cycle=%0d data=%04h expected=%04h", m, cycle, d, e);
        end
    endtask

    always @(negedge clk) begin
        if (m0_ack) got_ack(0, m0_dat);
        if (m1_ack) got_ack(1, m1_dat);
        if (b_m0_ack) got_ack(2, b_m0_dat);
        if (b_m1_ack) check("b_m1_unexpected_ack", 32'd1, 32'd0);
    end

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            ack_cnt[i]   = 0;
            first_ack[i] = -1;
            last_ack[i]  = -1;
        end
    endtask

    // Pipelined read burst; called and returns at posedge+1
    task automatic burst(input int m, input int n, input logic [15:0] base);
        int   sent;
        int   guard;
        logic acc;
        sent  = 0;
        guard = 0;
        start_cyc[m] = cycle;
        cyc_d[m] = 1'b1;
        stb_d[m] = 1'b1;
        adr_d[m] = base;
        while (sent < n && guard < 200) begin
            @(negedge clk);
            acc = ~stall_of(m);
            if (acc) begin
                push(m, rom_word(adr_d[m]));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                adr_d[m] = base + 16'(sent);
                if (sent == n) stb_d[m] = 1'b0;
            end
            guard++;
        end
        while (qsize(m) != 0 && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check($sformatf("m%0d_burst_done_in_time", m), {31'h0, guard < 200}, 32'd1);
        stb_d[m] = 1'b0;
        cyc_d[m] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst_n     = 1'b0;
        rom_clr   = 1'b1;
        rom_stall = 1'b0;
        rom_lat   = 1;
        for (int i = 0; i < 3; i++) begin
            cyc_d[i] = 1'b0;
            stb_d[i] = 1'b0;
            adr_d[i] = 16'h0000;
        end
        clear_stats();
        repeat (2) @(posedge clk);
        #1;
        rom_clr  = 1'b0;
        cyc_d[0] = 1'b1;
        stb_d[0] = 1'b1;
        #1;
        check("rst_s_cyc", {31'h0, s_cyc}, 32'd0);
        check("rst_s_stb", {31'h0, s_stb}, 32'd0);
        check("rst_m0_ack", {31'h0, m0_ack}, 32'd0);
        check("rst_m0_stall_eq_stb", {31'h0, m0_stall}, 32'd1);
        cyc_d[0] = 1'b0;
        stb_d[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        stb_d[1] = 1'b1;
        @(negedge clk);
        check("post_rst_m1_stall_eq_stb", {31'h0, m1_stall}, 32'd1);
        @(posedge clk);
        #1;
        stb_d[1] = 1'b0;
        @(negedge clk);
        check("post_rst_m1_stall_low", {31'h0, m1_stall}, 32'd0);
        check("post_rst_state_idle", 32'(dut.state_reg), 32'd0);
        @(posedge clk);
        #1;

        // single-master fetch
        clear_stats();
        burst(0, 4, 16'h0000);
        check("fetch_first_ack", first_ack[0], start_cyc[0] + 2);
        check("fetch_last_ack", last_ack[0], start_cyc[0] + 5);
        check("fetch_m0_acks", ack_cnt[0], 4);
        check("fetch_m1_acks", ack_cnt[1], 0);
        idle_cycles(3);

        // contention, two rounds
        for (int r = 0; r < 2; r++) begin
            clear_stats();
            fork
                burst(0, 1, 16'h0010 + 16'(r));
                burst(1, 1, 16'h0020 + 16'(r));
            join
            check("cont_m0_first_ack", first_ack[0], start_cyc[0] + 2);
            check("cont_m1_after_m0", {31'h0, first_ack[1] >= first_ack[0] + 3}, 32'd1);
            check("cont_m1_acks", ack_cnt[1], 1);
            idle_cycles(3);
        end

        // hold: m1 keeps the grant for 6 reads while m0 waits
        clear_stats();
        fork
            burst(1, 6, 16'h0040);
            begin
                idle_cycles(3);
                burst(0, 1, 16'h0080);
            end
        join
        check("hold_m1_acks", ack_cnt[1], 6);
        check("hold_m0_acks", ack_cnt[0], 1);
        check("hold_gap", {31'h0, first_ack[0] >= last_ack[1] + 3}, 32'd1);
        idle_cycles(3);

        // abort: m0 issues 2 reads to a slow ROM then drops cyc
        clear_stats();
        rom_lat  = 3;
        cyc_d[0] = 1'b1;
        stb_d[0] = 1'b1;
        adr_d[0] = 16'h0100;
        n0 = 0;
        for (int k = 0; k < 6 && n0 < 2; k++) begin
            @(negedge clk);
            if (!m0_stall) n0++;
            @(posedge clk);
            #1;
            adr_d[0] = 16'h0100 + 16'(n0);
        end
        cyc_d[0] = 1'b0;
        stb_d[0] = 1'b0;
        #1;
        check("abort_count_two", 32'(dut.count_reg), 32'd2);
        check("abort_s_cyc_drop", {31'h0, s_cyc}, 32'd0);
        idle_cycles(10);
        check("abort_m0_acks", ack_cnt[0], 0);
        check("abort_m1_acks", ack_cnt[1], 0);
        check("abort_count_zero", 32'(dut.count_reg), 32'd0);
        check("abort_state_idle", 32'(dut.state_reg), 32'd0);
        rom_lat = 1;
        burst(1, 1, 16'h0180);
        check("abort_then_m1_latency", first_ack[1], start_cyc[1] + 2);
        idle_cycles(3);

        // full: MAX_OUTSTANDING=1 gives alternate stall and one ack per 2 cycles
        clear_stats();
        fork
            burst(2, 4, 16'h0200);
            begin
                @(negedge clk);
                check("full_stall_idle", {31'h0, b_m0_stall}, 32'd1);
                for (int k = 1; k <= 6; k++) begin
                    @(negedge clk);
                    check($sformatf("full_stall_%0d", k), {31'h0, b_m0_stall}, {31'h0, (k % 2) == 0});
                end
            end
        join
        check("full_first_ack", first_ack[2], start_cyc[2] + 2);
        check("full_last_ack", last_ack[2], start_cyc[2] + 8);
        check("full_acks", ack_cnt[2], 4);
        idle_cycles(3);

        // reset mid-transfer with one read outstanding
        clear_stats();
        rom_lat  = 3;
        cyc_d[1] = 1'b1;
        stb_d[1] = 1'b1;
        adr_d[1] = 16'h0300;
        idle_cycles(1);
        @(negedge clk);
        check("rst_mid_m1_granted", {31'h0, m1_stall}, 32'd0);
        @(posedge clk);
        #1;
        stb_d[1] = 1'b0;
        #1;
        check("rst_mid_count_one", 32'(dut.count_reg), 32'd1);
        check("rst_mid_s_cyc_before", {31'h0, s_cyc}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_s_cyc", {31'h0, s_cyc}, 32'd0);
        check("rst_mid_s_stb", {31'h0, s_stb}, 32'd0);
        check("rst_mid_acks", {30'h0, m0_ack, m1_ack}, 32'd0);
        cyc_d[1] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        rom_lat = 1;
        @(posedge clk);
        #1;
        burst(0, 1, 16'h0400);
        check("rst_mid_m0_latency", first_ack[0], start_cyc[0] + 2);
        check("rst_mid_m1_no_ack", ack_cnt[1], 0);
        idle_cycles(3);

        check("queues_empty", qsize(0) + qsize(1) + qsize(2), 0);
        check("b_m1_stall_idle", {31'h0, b_m1_stall}, 32'd0);
        check("b_m1_dat_shared", {16'h0, b_m1_dat}, {16'h0, b_s_dat});
        check("m1_dat_shared", {16'h0, m1_dat}, {16'h0, s_dat});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
